reset_run_sequencer: RTL

- Synthesizable reset and run-window sequencer for the block-design wrapper (`design_1_wrapper`), replacing the hand-timed reset/run/stop sequence in the testbench.
- Holds downstream reset domains for a programmable time, then releases `NUM_CH` channel resets one after another at a fixed stagger.
- Opens a counted run window, then flags completion.
- Supports restart and a soft reset, so both hardware and the bench can drive repeatable bring-up sequences.

---
 rtl/reset_run_sequencer_pkg.sv | 10 +
 rtl/reset_run_sequencer_reset_sync.sv | 15 +
 rtl/reset_run_sequencer.sv | 78 +++++++
 3 files changed

// File: rtl/reset_run_sequencer_pkg.sv
// reset_run_sequencer_pkg: shared phase encoding and synchronizer depth
package rrs_pkg;
  typedef enum logic [1:0] {
    PH_HOLD    = 2'd0,
    PH_RELEASE = 2'd1,
    PH_RUN     = 2'd2,
    PH_DONE    = 2'd3
  } phase_e;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/reset_run_sequencer_reset_sync.sv
// reset_sync: asynchronous-assert, synchronous-deassert reset synchronizer
module reset_sync
  import rrs_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_rst_n
);
  logic [SYNC_STAGES-1:0] r_sync;
  // shift ones in after release; any low on i_rst_n clears the chain at once
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
  assign o_rst_n = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/reset_run_sequencer.sv
// reset_run_sequencer: hold, staggered channel release, counted run window, done
module reset_run_sequencer
  import rrs_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int HOLD_CYCLES    = 5,
  parameter int STAGGER_CYCLES = 2,
  parameter int RUN_CYCLES     = 50,
  parameter int CNT_W          = 16
) (
  input  logic              sys_clock,
  input  logic              reset_rtl,
  input  logic              start,
  input  logic              soft_rst_req,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic [1:0]        phase,
  output logic              run_active,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_count
);
  phase_e             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, r_cc, w_cc_nxt;
  logic [NUM_CH-1:0]  r_ch, w_ch_nxt;
  logic               r_run, r_done, w_rst_sync_n;

  reset_sync u_reset_sync (
    .i_clk   (sys_clock),
    .i_rst_n (reset_rtl),
    .o_rst_n (w_rst_sync_n)
  );

  // state, shared counter and registered outputs
  always_ff @(posedge sys_clock or negedge w_rst_sync_n)
    if (!w_rst_sync_n) begin
      r_state <= PH_HOLD;
      r_cnt   <= '0;
      r_ch    <= '0;
      r_run   <= 1'b0;
      r_done  <= 1'b0;
      r_cc    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_ch    <= w_ch_nxt;
      r_run   <= w_next == PH_RUN;
      r_done  <= w_next == PH_DONE;
      r_cc    <= w_cc_nxt;
    end

  // next state; soft reset overrides everything, counter restarts on any phase entry
  always_comb begin
    w_next = r_state;
    if (soft_rst_req) w_next = PH_HOLD;
    else
      case (r_state)
        PH_HOLD:    if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) w_next = PH_RELEASE;
        PH_RELEASE: if (r_cnt == CNT_W'((NUM_CH - 1) * STAGGER_CYCLES)) w_next = PH_RUN;
        PH_RUN:     if (r_cnt == CNT_W'(RUN_CYCLES - 1)) w_next = PH_DONE;
        default:    if (start) w_next = PH_HOLD;
      endcase
    w_cnt_nxt = (soft_rst_req || w_next != r_state || r_state == PH_DONE) ? '0 : r_cnt + CNT_W'(1);
  end

  // next output values, computed from the state being entered so outputs match the current cycle
  always_comb begin
    w_ch_nxt = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_ch_nxt[i] = w_next == PH_RUN || w_next == PH_DONE ||
                    (w_next == PH_RELEASE && w_cnt_nxt >= CNT_W'(i * STAGGER_CYCLES));
    w_cc_nxt = w_next == PH_RUN ? w_cnt_nxt : w_next == PH_DONE ? CNT_W'(RUN_CYCLES) : '0;
  end

  assign ch_rst_n    = r_ch;
  assign phase       = r_state;
  assign run_active  = r_run;
  assign done        = r_done;
  assign cycle_count = r_cc;
endmodule
